// File: rtl/arm_mem_arbiter.sv
// arm_mem_arbiter: single-port memory arbiter between IF fetch and MEM load/store, one access outstanding
//   Params : ADDR_W (word address width), MEM_LAT (read latency 1..15), STARVE_MAX (1..15)
//   Macro  : ARM_MEM_ARB_STARVE_GUARD_EN enables the fetch anti-starvation guard
//   IF     : if_req/if_addr/if_flush in, if_rdata/if_valid/stall_if out
//   MEM    : mem_req/mem_addr/mem_we/mem_wdata in, mem_rdata/mem_valid/stall_mem out
//   Memory : m_en/m_addr/m_we/m_wdata out, m_rdata in (valid MEM_LAT cycles after m_en)
module arm_mem_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_we,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              m_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_we,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_own, r_drop, r_wr;
  logic [31:0] r_if_rdata, r_mem_rdata;
  logic        w_if_elig, w_grant, w_grant_if, w_force, w_done;
  assign w_if_elig  = if_req & ~if_flush;
  assign w_grant    = (r_state == IDLE) & ~rst & (mem_req | w_if_elig);
  assign w_grant_if = w_force | ~mem_req;
  assign w_done     = (r_state == WAIT) & (r_cnt == 4'd1);
`ifdef ARM_MEM_ARB_STARVE_GUARD_EN
  logic [3:0] r_starve;
  assign w_force = (r_starve == 4'(STARVE_MAX)) & w_if_elig;
  // counts MEM grants that left an eligible fetch waiting
  always_ff @(posedge clk)
    if (rst) r_starve <= 4'd0;
    else if (w_grant) r_starve <= (~w_grant_if & w_if_elig) ? r_starve + 4'd1 : 4'd0;
`else
  assign w_force = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_grant ? WAIT : IDLE;
      WAIT:    w_next = w_done ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_cnt       <= 4'd0;
      r_own       <= 1'b0;
      r_drop      <= 1'b0;
      r_wr        <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      if (w_grant) begin
        r_own <= w_grant_if;
        r_wr  <= ~w_grant_if & (mem_we != 4'd0);
        r_cnt <= 4'(MEM_LAT);
      end
      if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
      if (w_done & r_own & ~r_drop & ~if_flush) r_if_rdata <= m_rdata;
      if (w_done & ~r_own & ~r_wr) r_mem_rdata <= m_rdata;
      if (r_state != IDLE & r_own & if_flush) r_drop <= 1'b1;
      if (r_state == RESP) r_drop <= 1'b0;
    end
  always_comb begin
    m_en      = w_grant;
    m_addr    = w_grant ? (w_grant_if ? if_addr : mem_addr) : '0;
    m_we      = (w_grant & ~w_grant_if) ? mem_we : 4'd0;
    m_wdata   = (w_grant & ~w_grant_if) ? mem_wdata : 32'd0;
    // a flush arriving during the response cycle still squashes the pulse
    if_valid  = ~rst & (r_state == RESP) & r_own & ~r_drop & ~if_flush;
    mem_valid = ~rst & (r_state == RESP) & ~r_own;
    if_rdata  = r_if_rdata;
    mem_rdata = r_mem_rdata;
    stall_if  = if_req & ~if_valid & ~if_flush;
    stall_mem = mem_req & ~mem_valid;
  end
endmodule

// File: tb/tb_arm_mem_arbiter.sv
// tb_arm_mem_arbiter: directed self-checking bench for arm_mem_arbiter
module tb_arm_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0, mem_req = 1'b0;
  logic [29:0] if_addr = '0, mem_addr = '0;
  logic [3:0]  mem_we = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] if_rdata, mem_rdata, m_wdata, m_rdata;
  logic        if_valid, mem_valid, stall_if, stall_mem, m_en;
  logic [29:0] m_addr;
  logic [3:0]  m_we;
  logic [31:0] d1, d2;
  int          n_tot = 0, n_pass = 0;
  arm_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .stall_if(stall_if), .stall_mem(stall_mem),
    .m_en(m_en), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [29:0] a);
    case (a[7:0])
      8'h10:   rom = 32'hE3A01005;
      8'h20:   rom = 32'hE1A00000;
      8'h30:   rom = 32'h11111111;
      8'h40:   rom = 32'h00001234;
      default: rom = 32'h0;
    endcase
  endfunction
  // two-cycle read latency memory stub
  always @(posedge clk) begin
    if (m_en) d1 <= rom(m_addr);
    d2 <= d1;
  end
  assign m_rdata = d2;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    logic        v;
    int          g;
    logic [29:0] ga [5];
    logic [29:0] exp5;
    step; step;
    chk("rst_m_en", m_en, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_wdata", m_wdata, 0);
    rst = 1'b0;
    step; if_req = 1; if_addr = 30'h10; #1;
    chk("f_m_en", m_en, 1);
    chk("f_m_addr", m_addr, 30'h10);
    chk("f_stall_T", stall_if, 1);
    step; #1;
    chk("f_m_en_T1", m_en, 0);
    chk("f_m_addr_idle", m_addr, 0);
    chk("f_stall_T1", stall_if, 1);
    step; #1;
    chk("f_valid_T2", if_valid, 0);
    chk("f_stall_T2", stall_if, 1);
    step; #1;
    chk("f_valid_T3", if_valid, 1);
    chk("f_rdata", if_rdata, 32'hE3A01005);
    chk("f_stall_T3", stall_if, 0);
    if_req = 0;
    step; #1;
    chk("f_valid_T4", if_valid, 0);
    step; if_req = 1; if_addr = 30'h20; mem_req = 1; mem_addr = 30'h40; #1;
    chk("s_m_addr_mem", m_addr, 30'h40);
    chk("s_stall_mem", stall_mem, 1);
    step; step; step; #1;
    chk("s_mem_valid", mem_valid, 1);
    chk("s_mem_rdata", mem_rdata, 32'h1234);
    chk("s_if_valid_early", if_valid, 0);
    chk("s_stall_mem_T3", stall_mem, 0);
    mem_req = 0;
    step; #1;
    chk("s_if_issue", m_en, 1);
    chk("s_if_addr", m_addr, 30'h20);
    step; step; step; #1;
    chk("s_if_valid", if_valid, 1);
    chk("s_if_rdata", if_rdata, 32'hE1A00000);
    if_req = 0;
    step; mem_req = 1; mem_addr = 30'h41; mem_we = 4'b0011; mem_wdata = 32'hAABBCCDD; #1;
    chk("w_m_we", m_we, 4'b0011);
    chk("w_m_wdata", m_wdata, 32'hAABBCCDD);
    step; #1;
    chk("w_m_we_T1", m_we, 0);
    chk("w_m_wdata_T1", m_wdata, 0);
    step; step; #1;
    chk("w_mem_valid", mem_valid, 1);
    chk("w_mem_rdata_held", mem_rdata, 32'h1234);
    mem_req = 0; mem_we = 0; mem_wdata = 0;
    step; if_req = 1; if_addr = 30'h30; #1;
    chk("fl_issue", m_en, 1);
    step; if_flush = 1; if_req = 0; #1;
    chk("fl_stall", stall_if, 0);
    step; if_flush = 0;
    step; #1;
    chk("fl_no_valid", if_valid, 0);
    chk("fl_rdata_held", if_rdata, 32'hE1A00000);
    step; mem_req = 1; mem_addr = 30'h40; #1;
    chk("fl_next_issue", m_en, 1);
    chk("fl_next_addr", m_addr, 30'h40);
    step; step; step; #1;
    chk("fl_mem_valid", mem_valid, 1);
    mem_req = 0;
    step; if_req = 1; if_addr = 30'h10; #1;
    chk("r_issue", m_en, 1);
    step; rst = 1; if_req = 0; #1;
    chk("r_m_en_in_rst", m_en, 0);
    step; rst = 0; #1;
    chk("r_if_rdata", if_rdata, 0);
    chk("r_mem_rdata", mem_rdata, 0);
    chk("r_m_en", m_en, 0);
    chk("r_if_valid", if_valid, 0);
    chk("r_m_addr", m_addr, 0);
    v = 0;
    for (int c = 0; c < 6; c++) begin
      step; v = v | if_valid | mem_valid;
    end
    chk("r_no_pulse", v, 0);
    for (int i = 0; i < 5; i++) ga[i] = '0;
    g = 0;
    mem_req = 1; mem_addr = 30'h40; if_req = 1; if_addr = 30'h10;
    for (int c = 0; c < 40 && g < 5; c++) begin
      #1;
      if (m_en) begin
        ga[g] = m_addr;
        g++;
      end
      step;
    end
`ifdef ARM_MEM_ARB_STARVE_GUARD_EN
    exp5 = 30'h10;
`else
    exp5 = 30'h40;
`endif
    chk("sv_grants", g, 5);
    chk("sv_grant1", ga[0], 30'h40);
    chk("sv_grant4", ga[3], 30'h40);
    chk("sv_grant5", ga[4], exp5);
    mem_req = 0; if_req = 0;
    for (int c = 0; c < 6; c++) step;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
